// File: rtl/imem_loader.sv
`default_nettype none
// =============================================================================
// imem_loader : parses a framed host byte stream into 32-bit words and loads
//               them into the programmable instruction-memory region.
// Revision    : 1.0
// =============================================================================
module imem_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_WORDS      = 512,
  parameter int         TIMEOUT_W      = 24,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [9:0]  imem_write_addr,
  output logic [31:0] imem_write_instr,
  output logic        imem_write_en,
  output logic        core_halt,
  output logic        load_done,
  output logic        load_err,
  output logic [9:0]  words_loaded
);

  localparam logic [16:0]          C_MAX_CNT      = 17'(MAX_WORDS);
  localparam logic [TIMEOUT_W-1:0] C_TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [7:0]           r_cnt_hi,    w_cnt_hi_nxt;
  logic [10:0]          r_word_cnt,  w_word_cnt_nxt;
  logic [1:0]           r_byte_idx,  w_byte_idx_nxt;
  logic [9:0]           r_word_idx,  w_word_idx_nxt;
  logic [23:0]          r_shift,     w_shift_nxt;
  logic [TIMEOUT_W-1:0] r_timer,     w_timer_nxt;
  logic [9:0]           r_addr,      w_addr_nxt;
  logic [31:0]          r_instr,     w_instr_nxt;
  logic                 r_wr_en,     w_wr_en_nxt;
  logic                 r_halt,      w_halt_nxt;
  logic                 r_done,      w_done_nxt;
  logic                 r_err,       w_err_nxt;
  logic [9:0]           r_loaded,    w_loaded_nxt;
  logic                 r_rx_ready;

  logic        w_accept;
  logic        w_active;
  logic        w_timeout;
  logic [15:0] w_cnt;
  logic        w_cnt_bad;
  logic        w_last_word;

  assign w_accept    = rx_valid && r_rx_ready;
  assign w_active    = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) || (r_state == S_DATA);
  assign w_timeout   = w_active && !w_accept && (r_timer == C_TIMEOUT_LAST);
  assign w_cnt       = {r_cnt_hi, rx_data};
  assign w_cnt_bad   = (w_cnt == 16'd0) || ({1'b0, w_cnt} > C_MAX_CNT);
  assign w_last_word = (({1'b0, r_word_idx} + 11'd1) == r_word_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt_hi   <= '0;
      r_word_cnt <= '0;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_shift    <= '0;
      r_timer    <= '0;
      r_addr     <= '0;
      r_instr    <= '0;
      r_wr_en    <= 1'b0;
      r_halt     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_loaded   <= '0;
      r_rx_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt_hi   <= w_cnt_hi_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_word_idx <= w_word_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_timer    <= w_timer_nxt;
      r_addr     <= w_addr_nxt;
      r_instr    <= w_instr_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_halt     <= w_halt_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_loaded   <= w_loaded_nxt;
      r_rx_ready <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_hi_nxt   = r_cnt_hi;
    w_word_cnt_nxt = r_word_cnt;
    w_byte_idx_nxt = r_byte_idx;
    w_word_idx_nxt = r_word_idx;
    w_shift_nxt    = r_shift;
    w_timer_nxt    = r_timer;
    w_addr_nxt     = r_addr;
    w_instr_nxt    = r_instr;
    w_wr_en_nxt    = 1'b0;
    w_halt_nxt     = r_halt;
    w_done_nxt     = 1'b0;
    w_err_nxt      = r_err;
    w_loaded_nxt   = r_loaded;

    if (w_active) begin
      w_timer_nxt = w_accept ? '0 : r_timer + TIMEOUT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept && (rx_data == SYNC_BYTE)) begin
          w_err_nxt    = 1'b0;
          w_loaded_nxt = '0;
          w_halt_nxt   = 1'b1;
          w_timer_nxt  = '0;
          w_state_nxt  = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (w_accept) begin
          w_cnt_hi_nxt = rx_data;
          w_state_nxt  = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (w_accept) begin
          if (w_cnt_bad) begin
            w_err_nxt   = 1'b1;
            w_halt_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_word_cnt_nxt = w_cnt[10:0];
            w_byte_idx_nxt = '0;
            w_word_idx_nxt = '0;
            w_state_nxt    = S_DATA;
          end
        end
      end
      S_DATA: begin
        // Sync byte values are payload here; every byte is shifted in big-endian.
        if (w_accept) begin
          w_byte_idx_nxt = r_byte_idx + 2'd1;
          w_shift_nxt    = {r_shift[15:0], rx_data};
          if (r_byte_idx == 2'd3) begin
            w_wr_en_nxt    = 1'b1;
            w_instr_nxt    = {r_shift, rx_data};
            w_addr_nxt     = r_word_idx;
            w_word_idx_nxt = r_word_idx + 10'd1;
            w_loaded_nxt   = r_loaded + 10'd1;
            if (w_last_word) begin
              w_state_nxt = S_FINISH;
            end
          end
        end
      end
      S_FINISH: begin
        // This cycle carries the final write strobe; completion follows it.
        w_done_nxt  = 1'b1;
        w_halt_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_timeout) begin
      w_err_nxt   = 1'b1;
      w_halt_nxt  = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  assign rx_ready         = r_rx_ready;
  assign imem_write_addr  = r_addr;
  assign imem_write_instr = r_instr;
  assign imem_write_en    = r_wr_en;
  assign core_halt        = r_halt;
  assign load_done        = r_done;
  assign load_err         = r_err;
  assign words_loaded     = r_loaded;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_imem_loader : directed and randomized frames checked against a frame-level
//                  reference model of the loader.
// Revision       : 1.0
// =============================================================================
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;
  typedef wr_t wq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  imem_write_addr;
  logic [31:0] imem_write_instr;
  logic        imem_write_en;
  logic        core_halt;
  logic        load_done;
  logic        load_err;
  logic [9:0]  words_loaded;

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int last_wr_cyc = 0;
  int wr_viol     = 0;
  wq_t got_q;

  always #5 clk = ~clk;

  imem_loader #(
    .SYNC_BYTE      (8'hA5),
    .MAX_WORDS      (512),
    .TIMEOUT_W      (24),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .imem_write_addr  (imem_write_addr),
    .imem_write_instr (imem_write_instr),
    .imem_write_en    (imem_write_en),
    .core_halt        (core_halt),
    .load_done        (load_done),
    .load_err         (load_err),
    .words_loaded     (words_loaded)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor; a write while the core is running or above the region is a violation.
  always @(negedge clk) begin
    if (imem_write_en) begin
      got_q.push_back({imem_write_addr, imem_write_instr});
      last_wr_cyc = cyc;
      if (!core_halt || imem_write_addr >= 10'd512) wr_viol++;
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    w = 0;
    while (!rx_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!rx_ready) check("rx_ready_wait", 64'(rx_ready), 64'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Frame-level model: skip to sync, read count, emit every complete word up to count.
  function automatic void model(input bq_t s, output wq_t ew, output bit edone,
                                output bit eerr, output int ewl);
    int p;
    int cnt;
    int avail;
    int n;
    p = 0;
    ew = {};
    while (p < s.size() && s[p] != 8'hA5) p++;
    cnt = int'(s[p+1]) * 256 + int'(s[p+2]);
    if (cnt == 0 || cnt > 512) begin
      edone = 1'b0;
      eerr  = 1'b1;
      ewl   = 0;
      return;
    end
    avail = (s.size() - p - 3) / 4;
    n     = (avail < cnt) ? avail : cnt;
    for (int i = 0; i < n; i++)
      ew.push_back({10'(i), s[p+3+4*i], s[p+4+4*i], s[p+5+4*i], s[p+6+4*i]});
    edone = (avail >= cnt);
    eerr  = !edone;
    ewl   = n;
  endfunction

  function automatic bq_t make_frame(input int cnt, input int nbytes);
    bq_t s;
    s = {};
    s.push_back(8'hA5);
    s.push_back(8'(cnt >> 8));
    s.push_back(8'(cnt));
    for (int i = 0; i < nbytes; i++)
      s.push_back(($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom));
    return s;
  endfunction

  task automatic check_writes(input string tag, input wq_t ew);
    wr_t g;
    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : '1;
      check($sformatf("%s_addr[%0d]", tag, i), 64'(g.a), 64'(ew[i].a));
      check($sformatf("%s_data[%0d]", tag, i), 64'(g.d), 64'(ew[i].d));
    end
  endtask

  task automatic run_frame(input string tag, input bq_t s, input int gapmax);
    wq_t ew;
    bit  ed;
    bit  ee;
    int  ewl;
    int  p;
    got_q.delete();
    done_cnt = 0;
    p = 0;
    while (p < s.size() && s[p] != 8'hA5) p++;
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      if (i == p) check({tag, "_halt_after_sync"}, 64'(core_halt), 64'd1);
    end
    model(s, ew, ed, ee, ewl);
    repeat (ed ? 4 : 110) @(negedge clk);
    check_writes(tag, ew);
    check({tag, "_done"}, 64'(done_cnt), ed ? 64'd1 : 64'd0);
    check({tag, "_err"}, 64'(load_err), 64'(ee));
    check({tag, "_words"}, 64'(words_loaded), 64'(ewl));
    check({tag, "_halt_end"}, 64'(core_halt), 64'd0);
    if (ed) check({tag, "_done_lat"}, 64'(done_cyc - last_wr_cyc), 64'd1);
  endtask

  initial begin
    bq_t s;
    wq_t ew;
    bit  ed;
    bit  ee;
    int  ewl;
    int  cnt;
    int  nb;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_wr_en", 64'(imem_write_en), 64'd0);
    check("rst_halt", 64'(core_halt), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_err", 64'(load_err), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    check("rst_addr", 64'(imem_write_addr), 64'd0);
    check("rst_instr", 64'(imem_write_instr), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rx_ready_after_rst", 64'(rx_ready), 64'd1);

    // Basic two-word load
    s = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("t1", s, 0);

    // Zero count, then a minimal valid frame clears the error
    s = '{8'hA5, 8'h00, 8'h00};
    run_frame("t2a", s, 0);
    s = '{8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    run_frame("t2b", s, 1);

    // Count above the region, then a full-region back-to-back load
    s = '{8'hA5, 8'h02, 8'h01};
    run_frame("t3a", s, 0);
    run_frame("t3b", make_frame(512, 2048), 0);

    // Garbage in idle is ignored; sync value inside payload is data
    got_q.delete();
    s = '{8'h00, 8'hFF, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      send_byte(s[i], 0);
      check($sformatf("t4_garbage_halt[%0d]", i), 64'(core_halt), 64'd0);
    end
    repeat (2) @(negedge clk);
    check("t4_garbage_nwrites", 64'(got_q.size()), 64'd0);
    check("t4_garbage_err", 64'(load_err), 64'd0);
    s = '{8'hA5, 8'h00, 8'h02, 8'hA5, 8'hA5, 8'h00, 8'h02, 8'h01, 8'hA5, 8'h03, 8'hA5};
    run_frame("t4", s, 0);

    // Inter-byte timeout after one and a half words
    got_q.delete();
    done_cnt = 0;
    s = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    for (int i = 0; i < s.size(); i++) send_byte(s[i], 0);
    repeat (97) @(negedge clk);
    check("t5_err_before", 64'(load_err), 64'd0);
    check("t5_halt_before", 64'(core_halt), 64'd1);
    repeat (5) @(negedge clk);
    check("t5_err_after", 64'(load_err), 64'd1);
    check("t5_halt_after", 64'(core_halt), 64'd0);
    check("t5_done", 64'(done_cnt), 64'd0);
    model(s, ew, ed, ee, ewl);
    check_writes("t5", ew);

    // Reset in the middle of a load
    got_q.delete();
    s = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    for (int i = 0; i < s.size(); i++) send_byte(s[i], 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_halt", 64'(core_halt), 64'd0);
    check("t6_rst_wr_en", 64'(imem_write_en), 64'd0);
    check("t6_rst_words", 64'(words_loaded), 64'd0);
    check("t6_partial_nwrites", 64'(got_q.size()), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_frame("t6", make_frame(3, 12), 0);

    // Randomized frames, some truncated to force a timeout
    for (int f = 0; f < 6; f++) begin
      cnt = int'($urandom_range(1, 24));
      nb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4 * cnt - 1)) : 4 * cnt;
      run_frame($sformatf("rnd%0d", f), make_frame(cnt, nb), 3);
    end

    check("write_violations", 64'(wr_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
